// File: rtl/collector_uart_if.sv
// Byte stream leaving the UART collector: data/valid/ready plus the two
// one-cycle status pulses (framing error, overrun).
interface collector_uart_if;
  logic [7:0] o_tdata;
  logic       o_tvalid;
  logic       i_tready;
  logic       o_frame_err;
  logic       o_overrun;

  // Collector side: produces the byte and status, consumes the accept.
  modport master (
    output o_tdata,
    output o_tvalid,
    output o_frame_err,
    output o_overrun,
    input  i_tready
  );

  // Downstream side: consumes the byte and status, produces the accept.
  modport slave (
    input  o_tdata,
    input  o_tvalid,
    input  o_frame_err,
    input  o_overrun,
    output i_tready
  );
endinterface

// File: rtl/collector_uart.sv
// 8N1 UART receiver feeding a one-deep valid/ready output register.
// The receiver never stalls: a byte that arrives while the previous one is
// still unconsumed is dropped and reported with a one-cycle overrun pulse.
module collector_uart #(
  parameter int clk_freq_hz = 16_000_000,
  parameter int baud_rate   = 57600
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_uart_rx,
  collector_uart_if.master m_rx
);

  // Bit period and half bit period in clock cycles.
  localparam int BIT   = clk_freq_hz / baud_rate;
  localparam int HALF  = BIT / 2;
  localparam int CNT_W = $clog2(BIT) + 1;

  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  // Receiver states.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Synchronizer and edge detection.
  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_rx_prev;
  logic [1:0]       r_sync_ok;
  logic             r_armed;

  // Receiver state.
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  // Output register.
  logic [7:0]       r_tdata;
  logic             r_tvalid;
  logic             r_frame_err;
  logic             r_overrun;

  // Combinational helpers.
  logic             w_tready;
  logic             w_fall;
  logic             w_sample;
  logic             w_deliver;
  logic             w_bad_stop;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;

  assign w_tready = m_rx.i_tready;

  // Two-flop synchronizer plus the previous synchronized value for edge
  // detection. r_sync_ok marks when r_rx_s holds a genuine line sample
  // rather than its reset value; r_armed is set once the genuine line has
  // been seen high, so a line that is already low out of reset cannot
  // masquerade as a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values and the two-stage chain really is two stages.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_sync_ok <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      r_sync_ok <= {r_sync_ok[0], 1'b1};
      if (r_sync_ok[1] && r_rx_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Start condition: synchronized line went 1 -> 0 after being seen high.
  assign w_fall     = r_armed && r_rx_prev && !r_rx_s;
  assign w_sample   = (r_cnt == '0);
  assign w_deliver  = (r_state == S_STOP) && w_sample && r_rx_s;
  assign w_bad_stop = (r_state == S_STOP) && w_sample && !r_rx_s;

  // Next-state logic: mid-bit sampling driven by the down-counter.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_HALF;
        end
      end
      S_START: begin
        if (w_sample) begin
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = CNT_BIT;
            w_bit_nxt   = 3'd0;
          end else begin
            // Line came back high before mid start bit: a glitch.
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (w_sample) begin
          // LSB arrives first, so shifting in at the MSB leaves bit 0 in
          // position 0 after the eighth sample.
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_bit_nxt   = r_bit_idx + 3'd1;
          w_cnt_nxt   = CNT_BIT;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (w_sample) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Receiver state registers.
  // NOTE: the shift register is reset along with the control state so that
  // an aborted frame can never leave a partial byte behind.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Output register: load on delivery when empty or being drained in the
  // same cycle, otherwise keep the old byte and flag an overrun; clear valid
  // after a handshake with no new delivery.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tdata     <= 8'h00;
      r_tvalid    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_bad_stop;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        if (!r_tvalid || w_tready) begin
          r_tdata  <= r_shift;
          r_tvalid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_tvalid && w_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_rx.o_tdata     = r_tdata;
  assign m_rx.o_tvalid    = r_tvalid;
  assign m_rx.o_frame_err = r_frame_err;
  assign m_rx.o_overrun   = r_overrun;

endmodule

// File: tb/tb_collector_uart.sv
// Self-checking bench for collector_uart at BIT=10, HALF=5.
// A frame-level reference model predicts the output register every cycle:
// each transmitted frame schedules a delivery (or framing error) at a fixed
// offset from the pin falling edge, and the output register follows the
// valid/ready rules.
`timescale 1ns/1ps
module tb_collector_uart;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;
  // Cycles from the first low synchronized sample to o_tvalid rising.
  localparam int LAT    = HALF + 9 * BIT + 1;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  collector_uart_if u_if ();

  collector_uart #(
    .clk_freq_hz (CLK_HZ),
    .baud_rate   (BAUD)
  ) u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_uart_rx (rx),
    .m_rx      (u_if)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checks
  int n_total = 0;
  int n_bad   = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------- reference model
  typedef struct {
    int unsigned at_edge;
    logic        ok;
    logic [7:0]  data;
  } ev_t;

  ev_t         ev_q[$];
  logic        m_valid = 1'b0;
  logic        m_ferr  = 1'b0;
  logic        m_ovr   = 1'b0;
  logic [7:0]  m_data  = 8'h00;

  always @(posedge clk) begin : model
    ev_t  e;
    logic dlv;
    cyc    = cyc + 1;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    dlv    = 1'b0;
    e      = '{at_edge: 0, ok: 1'b0, data: 8'h00};
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      ev_q.delete();
    end else begin
      if (ev_q.size() != 0 && ev_q[0].at_edge == cyc) begin
        e = ev_q.pop_front();
        if (e.ok) dlv = 1'b1;
        else      m_ferr = 1'b1;
      end
      if (dlv) begin
        if (!m_valid || u_if.i_tready) begin
          m_data  = e.data;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && u_if.i_tready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ------------------------------------------------ monitor / event counts
  int unsigned n_ferr = 0, n_ovr = 0, n_rise = 0, n_hi = 0, rise_cyc = 0;
  logic prev_v = 1'b0;

  always @(negedge clk) begin : monitor
    if (cyc > 0 && !rst) begin
      check("cycle", 32'({u_if.o_tvalid, u_if.o_frame_err, u_if.o_overrun, u_if.o_tdata}),
            32'({m_valid, m_ferr, m_ovr, m_data}));
    end
    if (u_if.o_frame_err === 1'b1) n_ferr++;
    if (u_if.o_overrun === 1'b1)   n_ovr++;
    if (u_if.o_tvalid === 1'b1) begin
      n_hi++;
      if (!prev_v) begin
        n_rise++;
        rise_cyc = cyc;
      end
    end
    prev_v = (u_if.o_tvalid === 1'b1);
  end

  int unsigned b_ferr, b_ovr, b_rise, b_hi;
  task automatic snap();
    b_ferr = n_ferr;
    b_ovr  = n_ovr;
    b_rise = n_rise;
    b_hi   = n_hi;
  endtask

  // ------------------------------------------------------------- stimulus
  int unsigned tx_start_edge = 0;

  // Drives one 8N1 frame on the pin, changing it on falling clock edges,
  // and schedules the expected outcome: the pin drop is seen by the first
  // synchronizer flop at posedge tx_start_edge and as rx_s one edge later.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rx            = 1'b0;
    tx_start_edge = cyc + 1;
    ev_q.push_back('{at_edge: tx_start_edge + 1 + LAT, ok: stop, data: d});
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_rise;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 0, 1, 0};
    vecs[2] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1, 0, 0};
    vecs[3] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1, 0, 0};
    vecs[4] = '{8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0, 1};
    vecs[5] = '{8'h99, 1'b0, 1'b0, 8'h11, 1'b1, 0, 1, 0};

    rst           = 1'b1;
    rx            = 1'b1;
    u_if.i_tready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_tvalid", 32'(u_if.o_tvalid), 32'd0);
    check("rst_tdata",  32'(u_if.o_tdata), 32'd0);
    check("rst_ferr",   32'(u_if.o_frame_err), 32'd0);
    check("rst_ovr",    32'(u_if.o_overrun), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Short low glitch on an idle line.
    snap();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_rise", n_rise - b_rise, 32'd0);
    check("glitch_ferr", n_ferr - b_ferr, 32'd0);
    check("glitch_ovr",  n_ovr - b_ovr, 32'd0);

    // 0xA5 latency and one-cycle valid with ready held high.
    u_if.i_tready = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1);
    repeat (5) @(negedge clk);
    check("a5_latency", rise_cyc - (tx_start_edge + 1), 32'(LAT));
    check("a5_width",   n_hi - b_hi, 32'd1);
    check("a5_data",    32'(u_if.o_tdata), 32'hA5);
    repeat (5) @(negedge clk);

    // Table: frame, stop bit and ready level -> state after the frame.
    for (int v = 0; v < 6; v++) begin
      u_if.i_tready = vecs[v].ready;
      snap();
      send_frame(vecs[v].data, vecs[v].stop);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_data", v),  32'(u_if.o_tdata), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_valid", v), 32'(u_if.o_tvalid), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_rise", v),  n_rise - b_rise, 32'(vecs[v].exp_rise));
      check($sformatf("vec%0d_ferr", v),  n_ferr - b_ferr, 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_ovr", v),   n_ovr - b_ovr, 32'(vecs[v].exp_ovr));
      repeat (4) @(negedge clk);
    end

    // One handshake drains the held 0x11.
    u_if.i_tready = 1'b1;
    @(negedge clk);
    check("drain_valid", 32'(u_if.o_tvalid), 32'd0);
    check("drain_data",  32'(u_if.o_tdata), 32'h11);
    u_if.i_tready = 1'b0;
    repeat (5) @(negedge clk);

    // Delivery of 0x77 coincides with the handshake of a pending 0x66.
    send_frame(8'h66, 1'b1);
    repeat (3) @(negedge clk);
    snap();
    fork
      send_frame(8'h77, 1'b1);
      begin
        bit hit;
        hit = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 300; k++) begin
          if (cyc == tx_start_edge + LAT) begin
            hit = 1'b1;
            break;
          end
          @(negedge clk);
        end
        check("coincide_sync", 32'(hit), 32'd1);
        u_if.i_tready = 1'b1;
        @(negedge clk);
        u_if.i_tready = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("coincide_data",  32'(u_if.o_tdata), 32'h77);
    check("coincide_valid", 32'(u_if.o_tvalid), 32'd1);
    check("coincide_ovr",   n_ovr - b_ovr, 32'd0);
    u_if.i_tready = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);

    // Reset during bit 4 of 0xF0, then 0x0F.
    snap();
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 300; k++) begin
          if (cyc == tx_start_edge + 4 * BIT + 4) break;
          @(negedge clk);
        end
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    check("rstmid_rise", n_rise - b_rise, 32'd0);
    check("rstmid_data", 32'(u_if.o_tdata), 32'd0);
    repeat (20) @(negedge clk);
    send_frame(8'h0F, 1'b1);
    repeat (5) @(negedge clk);
    check("after_rst_rise", n_rise - b_rise, 32'd1);
    check("after_rst_data", 32'(u_if.o_tdata), 32'h0F);
    check("after_rst_ferr", n_ferr - b_ferr, 32'd0);

    // Line already low when reset releases must be ignored.
    snap();
    @(negedge clk);
    rx = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (120) @(negedge clk);
    check("lowrst_rise", n_rise - b_rise, 32'd0);
    check("lowrst_ferr", n_ferr - b_ferr, 32'd0);
    check("lowrst_ovr",  n_ovr - b_ovr, 32'd0);
    send_frame(8'hC3, 1'b1);
    repeat (5) @(negedge clk);
    check("lowrst_next", 32'(u_if.o_tdata), 32'hC3);

    // Random frames, stop bits, gaps and ready; the model checks each cycle.
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          logic [7:0] d;
          logic       st;
          int         gap;
          for (int i = 0; i < 40; i++) begin
            d   = 8'($urandom_range(0, 255));
            st  = ($urandom_range(0, 4) != 0);
            send_frame(d, st);
            gap = int'($urandom_range(0, 12)) + (st ? 0 : 2);
            repeat (gap) @(negedge clk);
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(negedge clk);
            u_if.i_tready = 1'($urandom_range(0, 1));
          end
        end
      join
    end
    u_if.i_tready = 1'b1;
    repeat (150) @(negedge clk);
    check("final_valid", 32'(u_if.o_tvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/collector_uart.md
COLLECTOR_UART -- requirements
Module: collector_uart

Interface
REQ-001 The block SHALL have parameter clk_freq_hz, default 16_000_000, meaning the i_clk frequency in Hz.
REQ-002 The block SHALL have parameter baud_rate, default 57600, meaning the serial bit rate in bits/s.
REQ-003 The block SHALL have port i_clk, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit, reset; asynchronous, active-high.
REQ-005 The block SHALL have port i_uart_rx, input, 1 bit, the asynchronous serial line; it idles high.
REQ-006 The block SHALL have port o_tdata, output, 8 bits, the received byte.
REQ-007 The block SHALL have port o_tvalid, output, 1 bit, high while o_tdata holds an unconsumed byte.
REQ-008 The block SHALL have port i_tready, input, 1 bit, the downstream accept.
REQ-009 The block SHALL have port o_frame_err, output, 1 bit, a one-cycle pulse on a bad stop bit.
REQ-010 The block SHALL have port o_overrun, output, 1 bit, a one-cycle pulse when a received byte is dropped.

Function
REQ-011 The block SHALL define BIT = clk_freq_hz/baud_rate (integer division) and HALF = BIT/2; the counter SHALL be sized as $clog2(BIT)+1 bits.
REQ-012 The block SHALL pass i_uart_rx through a 2-flop synchronizer and use only the synchronized value (rx_s); the flops SHALL reset to 1.
REQ-013 The block SHALL implement a state machine with states IDLE, START, DATA, STOP.
REQ-014 In IDLE, a falling edge of rx_s (previous 1, current 0) SHALL move to START and load the counter with HALF-1; a line held low SHALL NOT retrigger.
REQ-015 In START, DATA and STOP, the counter SHALL decrement every cycle; the sample point is the cycle the counter equals 0.
REQ-016 At the START sample point, rx_s=0 SHALL move to DATA with the counter loaded to BIT-1 and bit index 0; rx_s=1 (glitch) SHALL return to IDLE with no output.
REQ-017 At each DATA sample point, the block SHALL shift rx_s into the MSB of an 8-bit shift register (LSB-first order), increment the bit index and reload the counter to BIT-1; after the 8th bit it SHALL move to STOP.
REQ-018 At the STOP sample point, the block SHALL return to IDLE unconditionally.
REQ-019 At the STOP sample point with rx_s=1, the block SHALL deliver the byte: on the next edge o_tdata <= shift register and o_tvalid <= 1.
REQ-020 At the STOP sample point with rx_s=0, o_frame_err SHALL pulse for exactly one cycle; no byte SHALL be delivered and o_tdata/o_tvalid SHALL be unchanged.
REQ-021 o_tvalid SHALL clear on the edge after a cycle with o_tvalid & i_tready, unless a delivery occurs on that same edge.
REQ-022 If delivery and handshake coincide, the new byte SHALL load and o_tvalid SHALL stay 1, with no overrun.
REQ-023 If a delivery occurs while o_tvalid=1 and i_tready=0, the old byte SHALL be kept, the new byte discarded, and o_overrun SHALL pulse for one cycle.
REQ-024 o_tdata SHALL remain stable while o_tvalid=1 and no handshake has occurred.
REQ-025 Latency from the first low rx_s to o_tvalid rising SHALL be HALF + 9*BIT + 1 cycles, plus 2 cycles of synchronizer delay from the pin.
REQ-026 Reception SHALL be independent of i_tready; the receiver SHALL never stall.

Reset
REQ-027 While i_rst=1, the block SHALL hold state=IDLE, counter=0, bit index=0, shift register=0, o_tdata=0, o_tvalid=0, o_frame_err=0, o_overrun=0, and synchronizer/edge flops=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no partial byte emitted.
REQ-029 After reset deasserts, the block SHALL require a fresh falling edge; a line already low SHALL be ignored until it returns high.

Verification (clk_freq_hz=1_000_000, baud_rate=100_000 -> BIT=10, HALF=5)
REQ-030 Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) with i_tready=1 -> o_tdata=0xA5, o_tvalid high exactly one cycle, 96 cycles after the rx_s falling edge.
REQ-031 Send a 3-cycle low glitch on an idle line -> return to IDLE; o_tvalid, o_frame_err and o_overrun all stay 0.
REQ-032 Send 0x3C with stop bit=0 -> o_frame_err pulses one cycle; o_tvalid stays 0; a following 0x55 with a valid stop bit is received correctly.
REQ-033 Send 0x11 then 0x22 back-to-back with i_tready=0 -> o_tdata=0x11 held; o_overrun pulses at the second delivery; raising i_tready then clears o_tvalid after one handshake.
REQ-034 Hold i_tready low until the cycle 0x77 delivers while 0x66 is pending -> no overrun; o_tdata=0x77 and o_tvalid stays 1.
REQ-035 Assert i_rst during bit 4 of 0xF0, then release and send 0x0F -> no output for 0xF0; 0x0F is received correctly.
